// File: rtl/cnn_layer_sequencer.sv
// Frame-level controller for the simpleCNN datapath: runs conv -> relu -> pool per
// channel, then fc, with a per-stage watchdog that aborts hung stages into ERR.
`timescale 1ns/1ps

module cnn_layer_sequencer #(
    parameter int NUM_CH  = 8,
    parameter int CH_W    = 3,
    parameter int TIMEOUT = 4000,
    parameter int TO_W    = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic            conv_done,
    input  logic            relu_done,
    input  logic            pool_done,
    input  logic            fc_done,
    output logic            conv_enable,
    output logic            relu_enable,
    output logic            pool_enable,
    output logic            fc_enable,
    output logic [CH_W-1:0] ch_sel,
    output logic            busy,
    output logic            result_valid,
    output logic            error,
    output logic [7:0]      frame_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONV,
        S_RELU,
        S_POOL,
        S_FC,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);
    localparam logic [TO_W-1:0] WD_LIMIT = TO_W'(TIMEOUT - 1);

    state_t          state_q, state_d;
    logic            enable_q;
    logic [TO_W-1:0] wd_q, wd_d;
    logic [CH_W-1:0] ch_sel_q, ch_sel_d;
    logic [7:0]      frame_cnt_q, frame_cnt_d;
    logic            conv_enable_q, conv_enable_d;
    logic            relu_enable_q, relu_enable_d;
    logic            pool_enable_q, pool_enable_d;
    logic            fc_enable_q, fc_enable_d;
    logic            busy_q, busy_d;
    logic            result_valid_q, result_valid_d;
    logic            error_q, error_d;

    logic start;
    logic stage_done;
    logic wd_expired;

    assign start      = enable & ~enable_q;
    assign wd_expired = (wd_q == WD_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            enable_q       <= 1'b0;
            wd_q           <= '0;
            ch_sel_q       <= '0;
            frame_cnt_q    <= '0;
            conv_enable_q  <= 1'b0;
            relu_enable_q  <= 1'b0;
            pool_enable_q  <= 1'b0;
            fc_enable_q    <= 1'b0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            enable_q       <= enable;
            wd_q           <= wd_d;
            ch_sel_q       <= ch_sel_d;
            frame_cnt_q    <= frame_cnt_d;
            conv_enable_q  <= conv_enable_d;
            relu_enable_q  <= relu_enable_d;
            pool_enable_q  <= pool_enable_d;
            fc_enable_q    <= fc_enable_d;
            busy_q         <= busy_d;
            result_valid_q <= result_valid_d;
            error_q        <= error_d;
        end
    end

    // Only the done belonging to the current stage is ever looked at.
    always_comb begin
        stage_done = 1'b0;
        case (state_q)
            S_CONV:  stage_done = conv_done;
            S_RELU:  stage_done = relu_done;
            S_POOL:  stage_done = pool_done;
            S_FC:    stage_done = fc_done;
            default: stage_done = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_ERR: begin
                if (start) state_d = S_CONV;
            end
            S_CONV: begin
                if (stage_done)      state_d = S_RELU;
                else if (wd_expired) state_d = S_ERR;
            end
            S_RELU: begin
                if (stage_done)      state_d = S_POOL;
                else if (wd_expired) state_d = S_ERR;
            end
            S_POOL: begin
                if (stage_done)      state_d = (ch_sel_q == LAST_CH) ? S_FC : S_CONV;
                else if (wd_expired) state_d = S_ERR;
            end
            S_FC: begin
                if (stage_done)      state_d = S_DONE;
                else if (wd_expired) state_d = S_ERR;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so each enable lines up with its state.
    always_comb begin
        ch_sel_d       = ch_sel_q;
        frame_cnt_d    = frame_cnt_q;
        wd_d           = '0;
        conv_enable_d  = (state_d == S_CONV);
        relu_enable_d  = (state_d == S_RELU);
        pool_enable_d  = (state_d == S_POOL);
        fc_enable_d    = (state_d == S_FC);
        busy_d         = !(state_d inside {S_IDLE, S_ERR});
        error_d        = (state_d == S_ERR);
        result_valid_d = (state_q == S_DONE);

        if ((state_q inside {S_IDLE, S_ERR}) && start) begin
            ch_sel_d = '0;
        end
        if ((state_q == S_POOL) && pool_done && (ch_sel_q != LAST_CH)) begin
            ch_sel_d = ch_sel_q + CH_W'(1);
        end
        if (state_q == S_DONE) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end

        // Watchdog restarts on every state change and only runs inside a stage.
        if ((state_d == state_q) && (state_q inside {S_CONV, S_RELU, S_POOL, S_FC})) begin
            wd_d = wd_q + TO_W'(1);
        end
    end

    assign conv_enable  = conv_enable_q;
    assign relu_enable  = relu_enable_q;
    assign pool_enable  = pool_enable_q;
    assign fc_enable    = fc_enable_q;
    assign ch_sel       = ch_sel_q;
    assign busy         = busy_q;
    assign result_valid = result_valid_q;
    assign error        = error_q;
    assign frame_cnt    = frame_cnt_q;

endmodule
